// File: rtl/shifter_pkg.sv
// Shared opcode encoding and opcode classification helpers for the pipelined shifter.
// Used by shifter_stage and shifter_pipe.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHIFT_SRL = 3'd0,
    SHIFT_SRA = 3'd1,
    SHIFT_SLL = 3'd2,
    SHIFT_ROR = 3'd3,
    SHIFT_ROL = 3'd4
  } shift_op_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= SHIFT_ROL;
  endfunction

  // Left ops run through the right-shift datapath on bit-reversed data.
  function automatic logic is_left_op(input logic [2:0] op);
    return (op == SHIFT_SLL) || (op == SHIFT_ROL);
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline slot: NUM_LVL right-shift mux levels starting at FIRST_LVL, then the slot register.
// The LAST slot also applies the saturation fill and undoes the left-op bit reversal.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1,
  parameter bit LAST      = 1'b0,
  localparam int AW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [AW-1:0]    in_amt_i,
  input  logic [2:0]       in_op_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             in_err_i,
  input  logic             in_sign_i,
  input  logic             in_sat_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [AW-1:0]    out_amt_o,
  output logic [2:0]       out_op_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o,
  output logic             out_sign_o,
  output logic             out_sat_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q, sign_q, sat_q;
  logic             load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // The rotate term uses WIDTH-sh with sh < WIDTH, so no shift-by-WIDTH ever occurs.
  function automatic logic [WIDTH-1:0] shiftLevel(input logic [WIDTH-1:0] d, input int sh,
                                                  input logic [2:0] op, input logic sign);
    logic [WIDTH-1:0] r;
    r = d >> sh;
    if (op == SHIFT_SRA && sign) r = r | ~({WIDTH{1'b1}} >> sh);
    if (op == SHIFT_ROR || op == SHIFT_ROL) r = r | (d << (WIDTH - sh));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] reverseBits(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  always_comb begin
    data_d = in_data_i;
    amt_d  = in_amt_i;
    for (int k = 0; k < NUM_LVL; k++) begin
      if (in_amt_i[FIRST_LVL+k]) data_d = shiftLevel(data_d, 1 << (FIRST_LVL + k), in_op_i, in_sign_i);
      amt_d[FIRST_LVL+k] = 1'b0;
    end
    if (LAST) begin
      if (in_sat_i) data_d = (in_op_i == SHIFT_SRA && in_sign_i) ? '1 : '0;
      if (is_left_op(in_op_i)) data_d = reverseBits(data_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      if (in_ready_o) valid_q <= in_valid_i;
      if (load) begin
        data_q <= data_d;
        amt_q  <= amt_d;
        op_q   <= in_op_i;
        tag_q  <= in_tag_i;
        err_q  <= in_err_i;
        sign_q <= in_sign_i;
        sat_q  <= in_sat_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_amt_o   = amt_q;
  assign out_op_o    = op_q;
  assign out_tag_o   = tag_q;
  assign out_err_o   = err_q;
  assign out_sign_o  = sign_q;
  assign out_sat_o   = sat_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and pass-through tag.
// Optional macro SHIFTER_PIPE_SAT_AMT_EN: amounts >= WIDTH saturate SRL/SRA/SLL instead of wrapping.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic [$clog2(WIDTH):0]   in_amt_i,
  input  logic [2:0]               in_op_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic                     out_err_o
);

  localparam int L   = $clog2(WIDTH);
  localparam int LPS = (L + STAGES - 1) / STAGES;

  logic             validPipe [STAGES+1];
  logic             readyPipe [STAGES+1];
  logic [WIDTH-1:0] dataPipe  [STAGES+1];
  logic [L-1:0]     amtPipe   [STAGES+1];
  logic [2:0]       opPipe    [STAGES+1];
  logic [TAG_W-1:0] tagPipe   [STAGES+1];
  logic             errPipe   [STAGES+1];
  logic             signPipe  [STAGES+1];
  logic             satPipe   [STAGES+1];

  logic [WIDTH-1:0] entryRev;
  logic             entryErr;
  logic             entrySat;
  logic             unusedTail;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign entryRev[i] = in_data_i[WIDTH-1-i];
  end

  // Reserved opcodes get a zero amount so the data flows through untouched.
  assign entryErr = !is_valid_op(in_op_i);

`ifdef SHIFTER_PIPE_SAT_AMT_EN
  assign entrySat = in_amt_i[L] &&
                    (in_op_i == SHIFT_SRL || in_op_i == SHIFT_SRA || in_op_i == SHIFT_SLL);
`else
  logic unusedAmtMsb;
  assign entrySat     = 1'b0;
  assign unusedAmtMsb = in_amt_i[L];
`endif

  assign validPipe[0] = in_valid_i;
  assign dataPipe[0]  = is_left_op(in_op_i) ? entryRev : in_data_i;
  assign amtPipe[0]   = entryErr ? '0 : in_amt_i[L-1:0];
  assign opPipe[0]    = in_op_i;
  assign tagPipe[0]   = in_tag_i;
  assign errPipe[0]   = entryErr;
  assign signPipe[0]  = in_data_i[WIDTH-1];
  assign satPipe[0]   = entrySat;

  assign readyPipe[STAGES] = out_ready_i;
  assign in_ready_o        = readyPipe[0];

  // Levels are split LSB-first; early slots take LPS levels each, the last takes whatever is left.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = (s * LPS < L) ? s * LPS : L;
    localparam int NUM   = (s == STAGES - 1) ? (L - FIRST) : ((L - FIRST < LPS) ? (L - FIRST) : LPS);

    shifter_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .FIRST_LVL(FIRST),
      .NUM_LVL  (NUM),
      .LAST     (s == STAGES - 1)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (validPipe[s]),
      .in_ready_o (readyPipe[s]),
      .in_data_i  (dataPipe[s]),
      .in_amt_i   (amtPipe[s]),
      .in_op_i    (opPipe[s]),
      .in_tag_i   (tagPipe[s]),
      .in_err_i   (errPipe[s]),
      .in_sign_i  (signPipe[s]),
      .in_sat_i   (satPipe[s]),
      .out_valid_o(validPipe[s+1]),
      .out_ready_i(readyPipe[s+1]),
      .out_data_o (dataPipe[s+1]),
      .out_amt_o  (amtPipe[s+1]),
      .out_op_o   (opPipe[s+1]),
      .out_tag_o  (tagPipe[s+1]),
      .out_err_o  (errPipe[s+1]),
      .out_sign_o (signPipe[s+1]),
      .out_sat_o  (satPipe[s+1])
    );
  end

  assign out_valid_o = validPipe[STAGES];
  assign out_data_o  = dataPipe[STAGES];
  assign out_tag_o   = tagPipe[STAGES];
  assign out_err_o   = errPipe[STAGES];

  assign unusedTail = ^{amtPipe[STAGES], opPipe[STAGES], signPipe[STAGES], satPipe[STAGES]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe (WIDTH=32, STAGES=2): directed cases plus random traffic
// against a scoreboard model computed from plain shift/rotate arithmetic.
module tb_shifter_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [5:0]  inAmt;
  logic [2:0]  inOp;
  logic [3:0]  inTag;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [3:0]  outTag;
  logic        outErr;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  shifter_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_data_i  (inData),
    .in_amt_i   (inAmt),
    .in_op_i    (inOp),
    .in_tag_i   (inTag),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_data_o (outData),
    .out_tag_o  (outTag),
    .out_err_o  (outErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no handshake, expected one within the cycle bound (t=%0t)", name, $time);
  endtask

  // Reference result {err, data} straight from the opcode definitions.
  function automatic logic [32:0] refResult(input logic [31:0] d, input logic [5:0] amt, input logic [2:0] op);
    int a, r;
    logic signed [31:0] sd, sra;
`ifdef SHIFTER_PIPE_SAT_AMT_EN
    a = int'(amt);
`else
    a = int'(amt) % 32;
`endif
    r   = a % 32;
    sd  = $signed(d);
    sra = sd >>> a;
    case (op)
      3'd0: return {1'b0, (a >= 32) ? 32'h0 : (d >> a)};
      3'd1: return {1'b0, (a >= 32) ? {32{d[31]}} : 32'(sra)};
      3'd2: return {1'b0, (a >= 32) ? 32'h0 : (d << a)};
      3'd3: return {1'b0, (r == 0) ? d : ((d >> r) | (d << (32 - r)))};
      3'd4: return {1'b0, (r == 0) ? d : ((d << r) | (d >> (32 - r)))};
      default: return {1'b1, d};
    endcase
  endfunction

  logic [31:0] expDataQ[$];
  logic [3:0]  expTagQ[$];
  logic        expErrQ[$];
  int          accCycQ[$];
  logic        frontSeen = 1'b0;
  logic        stallPrev = 1'b0;
  logic [31:0] stallData;
  logic [3:0]  stallTag;
  logic        stallErr;
  int          lastStall = -1;

  // Mid-cycle monitor: handshake bookkeeping, ordering, latency, stall stability.
  always @(negedge clk) begin
    logic [32:0] exp;
    int occ;
    if (!rstN) begin
      expDataQ.delete();
      expTagQ.delete();
      expErrQ.delete();
      accCycQ.delete();
      frontSeen = 1'b0;
      stallPrev = 1'b0;
    end else begin
      occ = expDataQ.size();
      checkOutput("in_ready", inReady, (occ < STAGES) || outReady);
      if (occ == 0) checkOutput("idle_valid", outValid, 1'b0);
      if (stallPrev) begin
        checkOutput("stall_valid", outValid, 1'b1);
        checkOutput("stall_data", outData, stallData);
        checkOutput("stall_tag", outTag, stallTag);
        checkOutput("stall_err", outErr, stallErr);
      end
      if (outValid && occ > 0) begin
        if (!frontSeen) begin
          frontSeen = 1'b1;
          if (lastStall < accCycQ[0]) checkOutput("latency", cycle - accCycQ[0], STAGES);
          else checkOutput("latency_min", (cycle - accCycQ[0]) >= STAGES, 1'b1);
        end
        if (!outReady) begin
          stallPrev = 1'b1;
          stallData = outData;
          stallTag  = outTag;
          stallErr  = outErr;
          lastStall = cycle;
        end else begin
          stallPrev = 1'b0;
          checkOutput("sb_data", outData, expDataQ.pop_front());
          checkOutput("sb_tag", outTag, expTagQ.pop_front());
          checkOutput("sb_err", outErr, expErrQ.pop_front());
          void'(accCycQ.pop_front());
          frontSeen = 1'b0;
        end
      end else begin
        stallPrev = 1'b0;
      end
      if (inValid && inReady) begin
        exp = refResult(inData, inAmt, inOp);
        expDataQ.push_back(exp[31:0]);
        expTagQ.push_back(inTag);
        expErrQ.push_back(exp[32]);
        accCycQ.push_back(cycle);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the op.
  task automatic applyStimulus(input logic [31:0] d, input logic [5:0] amt, input logic [2:0] op,
                               input logic [3:0] tag);
    logic accepted;
    inValid  = 1'b1;
    inData   = d;
    inAmt    = amt;
    inOp     = op;
    inTag    = tag;
    accepted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inReady) begin
        accepted = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (!accepted) failTimeout("accept");
    inValid = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [31:0] d, input logic [5:0] amt,
                             input logic [2:0] op, input logic [3:0] tag,
                             input logic [31:0] expData, input logic expErr);
    int lat;
    lat = 0;
    applyStimulus(d, amt, op, tag);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (outValid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) failTimeout({name, "_result"});
    else begin
      checkOutput({name, "_data"}, outData, expData);
      checkOutput({name, "_tag"}, outTag, tag);
      checkOutput({name, "_err"}, outErr, expErr);
      checkOutput({name, "_latency"}, lat, STAGES);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (expDataQ.size() == 0 && !outValid) break;
      @(negedge clk);
    end
    checkOutput({name, "_left_in_flight"}, expDataQ.size(), 0);
  endtask

  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inAmt    = '0;
    inOp     = '0;
    inTag    = '0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_out_data", outData, 32'h0);
    checkOutput("rst_out_tag", outTag, 4'h0);
    checkOutput("rst_out_err", outErr, 1'b0);
    checkOutput("rst_in_ready", inReady, 1'b1);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    runDirected("sra4", 32'h8000_0010, 6'd4, 3'd1, 4'hA, 32'hF800_0001, 1'b0);
    runDirected("sra_pos", 32'h7000_0000, 6'd4, 3'd1, 4'h3, 32'h0700_0000, 1'b0);
    runDirected("rol1", 32'h8000_0001, 6'd1, 3'd4, 4'h5, 32'h0000_0003, 1'b0);
    runDirected("ror0", 32'h8000_0001, 6'd0, 3'd3, 4'h6, 32'h8000_0001, 1'b0);
    runDirected("sll31", 32'h0000_FFFF, 6'd31, 3'd2, 4'h7, 32'h8000_0000, 1'b0);
    runDirected("sll0", 32'hDEAD_BEEF, 6'd0, 3'd2, 4'h8, 32'hDEAD_BEEF, 1'b0);
    runDirected("rsvd6", 32'h1234_5678, 6'd9, 3'd6, 4'hC, 32'h1234_5678, 1'b1);
`ifdef SHIFTER_PIPE_SAT_AMT_EN
    runDirected("srl40", 32'hFFFF_FFFF, 6'd40, 3'd0, 4'h1, 32'h0000_0000, 1'b0);
    runDirected("sra40", 32'h8000_0000, 6'd40, 3'd1, 4'h2, 32'hFFFF_FFFF, 1'b0);
`else
    runDirected("srl40", 32'hFFFF_FFFF, 6'd40, 3'd0, 4'h1, 32'h00FF_FFFF, 1'b0);
    runDirected("sra40", 32'h8000_0000, 6'd40, 3'd1, 4'h2, 32'hFF80_0000, 1'b0);
`endif
    runDirected("ror40", 32'h0000_0100, 6'd40, 3'd3, 4'h4, 32'h0000_0001, 1'b0);
    waitDrain("directed");

    $display("[TB] streaming 8 ops with a 3-cycle output stall");
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(32'h0101_0101 * (i + 1), 6'(i * 5), 3'(i % 5), 4'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    waitDrain("stream");

    $display("[TB] reset with two ops in flight");
    applyStimulus(32'hAAAA_5555, 6'd3, 3'd0, 4'h9);
    applyStimulus(32'h5555_AAAA, 6'd7, 3'd3, 4'hB);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_valid", outValid, 1'b0);
    checkOutput("midrst_data", outData, 32'h0);
    checkOutput("midrst_tag", outTag, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    runDirected("post_rst", 32'h0000_00F0, 6'd4, 3'd0, 4'hD, 32'h0000_000F, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_alone", outValid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    begin
      logic doneFlag;
      doneFlag = 1'b0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            applyStimulus($urandom, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)));
          end
          doneFlag = 1'b1;
        end
        begin
          while (!doneFlag) begin
            @(posedge clk);
            #1;
            outReady = ($urandom_range(0, 3) != 0);
          end
          outReady = 1'b1;
        end
      join
    end
    waitDrain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish before 500000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
